// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcode encodings and the writeback-stage FSM states.
package lc2k_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NOR  = 3'd1;
   localparam logic [2:0] OP_LW   = 3'd2;
   localparam logic [2:0] OP_SW   = 3'd3;
   localparam logic [2:0] OP_BEQ  = 3'd4;
   localparam logic [2:0] OP_JALR = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;
   localparam logic [2:0] OP_NOOP = 3'd7;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      HALT_RET = 2'd1,
      HALTED   = 2'd2
   } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/mem_wb_stage.sv
// LC2K MEM/WB pipeline register and writeback: selects the write value, drives the
// register-file write port and forwarding bus, counts retirements and latches HALT.
module mem_wb_stage
   import lc2k_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int REG_ADDR_W = 3,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_opcode,
   input  logic [REG_ADDR_W-1:0] in_dest_reg,
   input  logic [WORD_W-1:0]     in_alu_result,
   input  logic [WORD_W-1:0]     in_mem_result,
   input  logic [WORD_W-1:0]     in_pc_plus1,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [WORD_W-1:0]     rf_wdata,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_reg,
   output logic [WORD_W-1:0]     fwd_data,
   output logic                  halted,
   output logic [CNT_W-1:0]      retire_count
);

   wb_state_e             state_q, state_d;
   logic                  valid_q;
   logic [2:0]            opcode_q;
   logic [REG_ADDR_W-1:0] dest_q;
   logic [WORD_W-1:0]     alu_q, mem_q, pc1_q;
   logic                  transfer;
   logic                  wb_we;
   logic [WORD_W-1:0]     wb_data;

   assign in_ready = (state_q == RUN) && !reset;
   assign transfer = in_valid && in_ready;
   assign halted   = (state_q == HALTED);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= transfer;
      end
   end

   // NOTE: the payload is not reset; it is only observed through valid_q, which is.
   always_ff @(posedge clk) begin
      if (transfer) begin
         opcode_q <= in_opcode;
         dest_q   <= in_dest_reg;
         alu_q    <= in_alu_result;
         mem_q    <= in_mem_result;
         pc1_q    <= in_pc_plus1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:      if (transfer && (in_opcode == OP_HALT)) state_d = HALT_RET;
         HALT_RET: state_d = HALTED;
         HALTED:   state_d = HALTED;
         default:  state_d = RUN;
      endcase
   end

   // Reset gates the write so an in-flight instruction never reaches the register file.
   always_comb begin
      wb_we   = 1'b0;
      wb_data = '0;
      if (valid_q && !reset) begin
         case (opcode_q)
            OP_ADD, OP_NOR: begin wb_we = 1'b1; wb_data = alu_q; end
            OP_LW:          begin wb_we = 1'b1; wb_data = mem_q; end
            OP_JALR:        begin wb_we = 1'b1; wb_data = pc1_q; end
            default:        ;
         endcase
      end
   end

   assign rf_we     = wb_we;
   assign rf_waddr  = wb_we ? dest_q : '0;
   assign rf_wdata  = wb_data;
   assign fwd_valid = rf_we;
   assign fwd_reg   = rf_waddr;
   assign fwd_data  = rf_wdata;

   sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (valid_q),
      .count (retire_count)
   );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage; a second instance with a 2-bit counter exercises saturation.
module tb_mem_wb_stage;
   import lc2k_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_opcode;
   logic [2:0]  in_dest_reg;
   logic [31:0] in_alu_result, in_mem_result, in_pc_plus1;
   logic        rf_we, fwd_valid, halted;
   logic [2:0]  rf_waddr, fwd_reg;
   logic [31:0] rf_wdata, fwd_data, retire_count;

   logic        s_in_ready, s_rf_we, s_fwd_valid, s_halted;
   logic [2:0]  s_rf_waddr, s_fwd_reg;
   logic [31:0] s_rf_wdata, s_fwd_data;
   logic [1:0]  s_retire_count;

   typedef struct packed {
      logic        we;
      logic [2:0]  waddr;
      logic [31:0] wdata;
   } wb_t;

   wb_t         exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          m_state;
   logic        m_valid;
   logic [31:0] m_count;
   logic [1:0]  m_small;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_dest_reg(in_dest_reg), .in_alu_result(in_alu_result),
      .in_mem_result(in_mem_result), .in_pc_plus1(in_pc_plus1),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
      .halted(halted), .retire_count(retire_count)
   );

   mem_wb_stage #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_opcode(in_opcode), .in_dest_reg(in_dest_reg), .in_alu_result(in_alu_result),
      .in_mem_result(in_mem_result), .in_pc_plus1(in_pc_plus1),
      .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
      .fwd_valid(s_fwd_valid), .fwd_reg(s_fwd_reg), .fwd_data(s_fwd_data),
      .halted(s_halted), .retire_count(s_retire_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic wb_t wb_model(input logic [2:0] op, input logic [2:0] dest,
                                    input logic [31:0] alu, input logic [31:0] mem,
                                    input logic [31:0] pc1);
      wb_t r = '0;
      case (op)
         3'd0, 3'd1: r = '{we: 1'b1, waddr: dest, wdata: alu};
         3'd2:       r = '{we: 1'b1, waddr: dest, wdata: mem};
         3'd5:       r = '{we: 1'b1, waddr: dest, wdata: pc1};
         default:    r = '0;
      endcase
      return r;
   endfunction

   task automatic compare_outputs();
      wb_t e;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
         return;
      end
      e = exp_q.pop_front();
      check("rf_we", 64'(rf_we), 64'(e.we));
      check("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
      check("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
      check("fwd_valid", 64'(fwd_valid), 64'(e.we));
      check("fwd_reg", 64'(fwd_reg), 64'(e.waddr));
      check("fwd_data", 64'(fwd_data), 64'(e.wdata));
      check("retire_count", 64'(retire_count), 64'(m_count));
      check("sat_count", 64'(s_retire_count), 64'(m_small));
      check("halted", 64'(halted), 64'(m_state == 2));
   endtask

   // Called at a negedge: checks the current cycle, drives the next input, advances one clock.
   task automatic cycle(input logic v, input logic [2:0] op, input logic [2:0] dest,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc1);
      logic xfer;
      compare_outputs();
      check("in_ready", 64'(in_ready), 64'(m_state == 0));
      in_valid = v; in_opcode = op; in_dest_reg = dest;
      in_alu_result = alu; in_mem_result = mem; in_pc_plus1 = pc1;
      xfer = v && (m_state == 0);
      exp_q.push_back(xfer ? wb_model(op, dest, alu, mem, pc1) : wb_t'('0));
      @(posedge clk);
      if (m_valid) begin
         if (m_count != '1) m_count++;
         if (m_small != 2'b11) m_small++;
      end
      m_valid = xfer;
      if (m_state == 0 && xfer && op == 3'd6) m_state = 1;
      else if (m_state == 1) m_state = 2;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_rf_we", 64'(rf_we), 64'd0);
      check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
      check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
      check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_count", 64'(retire_count), 64'd0);
      reset = 1'b0;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);
      m_state = 0; m_valid = 1'b0; m_count = '0; m_small = '0;
      exp_q.delete();
      exp_q.push_back('0);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_dest_reg = '0;
      in_alu_result = '0; in_mem_result = '0; in_pc_plus1 = '0;
      @(negedge clk);
      do_reset();

      cycle(1'b1, OP_ADD,  3'd3, 32'h0000_0007, 32'h0, 32'h0);
      cycle(1'b1, OP_LW,   3'd2, 32'd9, 32'hFFFF_FFFF, 32'h0);
      cycle(1'b1, OP_JALR, 3'd4, 32'h55, 32'h66, 32'd12);
      cycle(1'b1, OP_SW,   3'd1, 32'h11, 32'h22, 32'h33);
      cycle(1'b1, OP_BEQ,  3'd6, 32'h44, 32'h55, 32'h66);
      cycle(1'b1, OP_NOOP, 3'd7, 32'h77, 32'h88, 32'h99);
      repeat (3) cycle(1'b0, OP_ADD, 3'd5, 32'hDEAD, 32'h0, 32'h0);
      cycle(1'b1, OP_NOR,  3'd0, 32'hA5A5_5A5A, 32'h0, 32'h0);
      cycle(1'b1, OP_HALT, 3'd0, 32'h0, 32'h0, 32'h0);
      repeat (4) cycle(1'b1, OP_ADD, 3'd5, 32'd99, 32'h0, 32'h0);
      cycle(1'b0, OP_NOOP, 3'd0, 32'h0, 32'h0, 32'h0);

      do_reset();
      for (int i = 0; i < 5; i++)
         cycle(1'b1, OP_ADD, 3'(i), 32'(i + 100), 32'h0, 32'h0);
      cycle(1'b0, OP_NOOP, 3'd0, 32'h0, 32'h0, 32'h0);

      do_reset();
      cycle(1'b1, OP_LW, 3'd6, 32'h4, 32'hCAFE_F00D, 32'h0);
      compare_outputs();
      reset = 1'b1; in_valid = 1'b0;
      #1;
      check("midrst_rf_we", 64'(rf_we), 64'd0);
      check("midrst_fwd_valid", 64'(fwd_valid), 64'd0);
      check("midrst_rf_wdata", 64'(rf_wdata), 64'd0);
      do_reset();
      cycle(1'b0, OP_NOOP, 3'd0, 32'h0, 32'h0, 32'h0);
      compare_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
